// File: rtl/split_mem_pkg.sv
// Shared types and constants for the split instruction/data memory controller.
package split_mem_pkg;

    typedef enum logic {IDLE, BUSY} port_state_e;

    localparam logic [31:0] NOP_WORD_DEFAULT = 32'hC800_0000;
    localparam int          LAT_CNT_W        = 3;

endpackage

// File: rtl/split_mem_ctrl_port.sv
// mem_port_ctrl: one port's IDLE/BUSY FSM, latency counter and response register.
// The read word is captured at acceptance, so later writes cannot disturb it.
module mem_port_ctrl
    import split_mem_pkg::*;
#(
    parameter int                DATA_W    = 32,
    parameter int                LATENCY   = 1,
    parameter logic [DATA_W-1:0] IDLE_DATA = '0,
    parameter bit                HOLD_LAST = 1'b0
) (
    input  logic              mem_clk,
    input  logic              nreset,
    input  logic              req,
    input  logic              rsp_needed,
    input  logic              err_in,
    input  logic [DATA_W-1:0] data_in,
    output logic              ready,
    output logic              rvalid,
    output logic              err,
    output logic [DATA_W-1:0] rdata
);

    port_state_e          state_q, state_d;
    logic [LAT_CNT_W-1:0] cnt_q, cnt_d;
    logic [DATA_W-1:0]    rsp_q, rsp_d;
    logic [DATA_W-1:0]    last_q, last_d;
    logic                 err_q, err_d;

    always_ff @(posedge mem_clk or negedge nreset) begin
        if (!nreset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rsp_q   <= '0;
            last_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rsp_q   <= rsp_d;
            last_q  <= last_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rsp_d   = rsp_q;
        last_d  = last_q;
        err_d   = err_q;
        ready   = 1'b0;
        rvalid  = 1'b0;
        case (state_q)
            IDLE: begin
                ready = 1'b1;
                // Writes without an error response never leave IDLE.
                if (req && rsp_needed) begin
                    state_d = BUSY;
                    cnt_d   = LAT_CNT_W'(LATENCY - 1);
                    rsp_d   = data_in;
                    err_d   = err_in;
                end
            end
            BUSY: begin
                if (cnt_q == '0) begin
                    rvalid  = 1'b1;
                    state_d = IDLE;
                    last_d  = rsp_q;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign err   = rvalid & err_q;
    assign rdata = rvalid ? rsp_q : (HOLD_LAST ? last_q : IDLE_DATA);

endmodule

// File: rtl/split_mem_ctrl.sv
// Split instruction (read-only) / data memory over one byte-addressed store.
// Define SPLIT_MEM_ALIGN_CHECK_EN to turn unaligned accesses into error responses.
module split_mem_ctrl
    import split_mem_pkg::*;
#(
    parameter int                ADDR_W      = 32,
    parameter int                DATA_W      = 32,
    parameter int                DEPTH_BYTES = 65536,
    parameter int                LATENCY     = 1,
    parameter logic [DATA_W-1:0] NOP_WORD    = DATA_W'(NOP_WORD_DEFAULT)
) (
    input  logic                mem_clk,
    input  logic                nreset,
    input  logic                i_req,
    input  logic [ADDR_W-1:0]   i_addr,
    output logic                i_ready,
    output logic                i_rvalid,
    output logic [DATA_W-1:0]   i_rdata,
    output logic                i_err,
    input  logic                d_req,
    input  logic                d_we,
    input  logic [DATA_W/8-1:0] d_be,
    input  logic [ADDR_W-1:0]   d_addr,
    input  logic [DATA_W-1:0]   d_wdata,
    output logic                d_ready,
    output logic                d_rvalid,
    output logic [DATA_W-1:0]   d_rdata,
    output logic                d_err
);

    localparam int NB    = DATA_W / 8;
    localparam int AW    = $clog2(DEPTH_BYTES);
    localparam int OFS_W = (NB > 1) ? $clog2(NB) : 1;

    logic [7:0]        mem [DEPTH_BYTES];
    logic [DATA_W-1:0] i_word, d_word;
    logic              i_mis, d_mis, d_wr_en;
    logic              unused_addr_bits;

    // Byte k of a word comes from (addr + k) mod DEPTH_BYTES, so words wrap.
    always_comb begin
        i_word = '0;
        d_word = '0;
        for (int k = 0; k < NB; k++) begin
            i_word[8*k +: 8] = mem[AW'(i_addr[AW-1:0] + AW'(k))];
            d_word[8*k +: 8] = mem[AW'(d_addr[AW-1:0] + AW'(k))];
        end
    end

`ifdef SPLIT_MEM_ALIGN_CHECK_EN
    assign i_mis = (NB > 1) && (i_addr[OFS_W-1:0] != '0);
    assign d_mis = (NB > 1) && (d_addr[OFS_W-1:0] != '0);
`else
    assign i_mis = 1'b0;
    assign d_mis = 1'b0;
`endif

    assign unused_addr_bits = ^{i_addr, d_addr};
    assign d_wr_en = nreset && d_req && d_ready && d_we && !d_mis;

    always_ff @(posedge mem_clk) begin
        if (d_wr_en) begin
            for (int k = 0; k < NB; k++) begin
                if (d_be[k]) mem[AW'(d_addr[AW-1:0] + AW'(k))] <= d_wdata[8*k +: 8];
            end
        end
    end

    mem_port_ctrl #(
        .DATA_W(DATA_W), .LATENCY(LATENCY), .IDLE_DATA(NOP_WORD), .HOLD_LAST(1'b0)
    ) u_i_port (
        .mem_clk    (mem_clk),
        .nreset     (nreset),
        .req        (i_req),
        .rsp_needed (1'b1),
        .err_in     (i_mis),
        .data_in    (i_mis ? '0 : i_word),
        .ready      (i_ready),
        .rvalid     (i_rvalid),
        .err        (i_err),
        .rdata      (i_rdata)
    );

    mem_port_ctrl #(
        .DATA_W(DATA_W), .LATENCY(LATENCY), .IDLE_DATA('0), .HOLD_LAST(1'b1)
    ) u_d_port (
        .mem_clk    (mem_clk),
        .nreset     (nreset),
        .req        (d_req),
        .rsp_needed (!d_we || d_mis),
        .err_in     (d_mis),
        .data_in    (d_mis ? '0 : d_word),
        .ready      (d_ready),
        .rvalid     (d_rvalid),
        .err        (d_err),
        .rdata      (d_rdata)
    );

endmodule

// File: tb/tb_split_mem_ctrl.sv
// Randomised bench for split_mem_ctrl: a cycle-indexed transaction model is
// compared against the DUT every cycle, with a few literal anchor checks.
module tb_split_mem_ctrl;

    localparam int          LAT   = 3;
    localparam int          DEPTH = 65536;
    localparam logic [31:0] NOP   = 32'hC800_0000;
`ifdef SPLIT_MEM_ALIGN_CHECK_EN
    localparam bit ALIGN = 1'b1;
`else
    localparam bit ALIGN = 1'b0;
`endif

    logic        mem_clk = 1'b0;
    logic        nreset  = 1'b0;
    logic        i_req = 1'b0, d_req = 1'b0, d_we = 1'b0;
    logic [31:0] i_addr = '0, d_addr = '0, d_wdata = '0;
    logic [3:0]  d_be = '0;
    logic        i_ready, i_rvalid, i_err, d_ready, d_rvalid, d_err;
    logic [31:0] i_rdata, d_rdata;

    int total = 0;
    int bad   = 0;

    split_mem_ctrl #(
        .ADDR_W(32), .DATA_W(32), .DEPTH_BYTES(DEPTH), .LATENCY(LAT), .NOP_WORD(NOP)
    ) dut (
        .mem_clk(mem_clk), .nreset(nreset),
        .i_req(i_req), .i_addr(i_addr), .i_ready(i_ready), .i_rvalid(i_rvalid),
        .i_rdata(i_rdata), .i_err(i_err),
        .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ready(d_ready), .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err)
    );

    always #5 mem_clk = ~mem_clk;

    // Model: byte array plus, per port, the cycle index until which it is busy
    // and the cycle in which its pending response appears.
    logic [7:0]  mem_m [DEPTH];
    int          cyc = 0;
    int          i_busy = -1, i_rsp_cyc = -1, d_busy = -1, d_rsp_cyc = -1;
    logic [31:0] i_rsp_data = '0, d_rsp_data = '0, d_last = '0;
    logic        i_rsp_err = 1'b0, d_rsp_err = 1'b0;

    function automatic logic [31:0] m_read(input logic [31:0] a);
        logic [31:0] w;
        for (int k = 0; k < 4; k++) w[8*k +: 8] = mem_m[(longint'(a) + k) % DEPTH];
        return w;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        i_busy = -1; i_rsp_cyc = -1; d_busy = -1; d_rsp_cyc = -1; d_last = '0;
    endtask

    task automatic model_edge(input logic ir, input logic [31:0] ia, input logic dr,
                              input logic dw, input logic [3:0] dbe,
                              input logic [31:0] da, input logic [31:0] dwd);
        if (cyc == d_rsp_cyc) d_last = d_rsp_data;
        if (nreset) begin
            bit i_ok = cyc > i_busy;
            bit d_ok = cyc > d_busy;
            if (ir && i_ok) begin
                i_busy = cyc + LAT; i_rsp_cyc = cyc + LAT;
                i_rsp_err  = ALIGN && (ia % 4 != 0);
                i_rsp_data = i_rsp_err ? 32'h0 : m_read(ia);
            end
            if (dr && d_ok) begin
                if (ALIGN && (da % 4 != 0)) begin
                    d_busy = cyc + LAT; d_rsp_cyc = cyc + LAT;
                    d_rsp_err = 1'b1; d_rsp_data = '0;
                end else if (dw) begin
                    for (int k = 0; k < 4; k++)
                        if (dbe[k]) mem_m[(longint'(da) + k) % DEPTH] = dwd[8*k +: 8];
                end else begin
                    d_busy = cyc + LAT; d_rsp_cyc = cyc + LAT;
                    d_rsp_err = 1'b0; d_rsp_data = m_read(da);
                end
            end
        end
        cyc++;
    endtask

    // Drive one cycle's request, let the edge pass, return at the next negedge.
    task automatic step(input logic ir, input logic [31:0] ia, input logic dr,
                        input logic dw, input logic [3:0] dbe,
                        input logic [31:0] da, input logic [31:0] dwd);
        i_req = ir; i_addr = ia; d_req = dr; d_we = dw; d_be = dbe; d_addr = da; d_wdata = dwd;
        @(posedge mem_clk);
        model_edge(ir, ia, dr, dw, dbe, da, dwd);
        @(negedge mem_clk);
        i_req = 1'b0; d_req = 1'b0;
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 4'h0, 0, 0);
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] w, input logic [3:0] be);
        step(0, 0, 1, 1, be, a, w);
    endtask

    // Watch a port for 8 cycles: cycles with ready low, rvalid pulses, returned data.
    task automatic watch(input bit is_d, output int lowc, output int vc,
                         output logic [31:0] data, output logic err);
        lowc = 0; vc = 0; data = '0; err = 1'b0;
        for (int j = 0; j < 8; j++) begin
            if (!(is_d ? d_ready : i_ready)) lowc++;
            if (is_d ? d_rvalid : i_rvalid) begin
                vc++;
                data = is_d ? d_rdata : i_rdata;
                err  = is_d ? d_err : i_err;
            end
            idle();
        end
    endtask

    always @(negedge mem_clk) begin
        bit iv, dv;
        iv = (cyc == i_rsp_cyc);
        dv = (cyc == d_rsp_cyc);
        chk("i_ready",  {31'b0, i_ready},  {31'b0, cyc > i_busy});
        chk("i_rvalid", {31'b0, i_rvalid}, {31'b0, iv});
        chk("i_rdata",  i_rdata,           iv ? i_rsp_data : NOP);
        chk("i_err",    {31'b0, i_err},    {31'b0, iv && i_rsp_err});
        chk("d_ready",  {31'b0, d_ready},  {31'b0, cyc > d_busy});
        chk("d_rvalid", {31'b0, d_rvalid}, {31'b0, dv});
        chk("d_rdata",  d_rdata,           dv ? d_rsp_data : d_last);
        chk("d_err",    {31'b0, d_err},    {31'b0, dv && d_rsp_err});
    end

    initial begin
        int          lowc, vc;
        logic [31:0] data, a;
        logic        err;

        idle(); idle();
        chk("rst_i_rdata", i_rdata, 32'hC800_0000);
        chk("rst_ready",   {30'b0, i_ready, d_ready}, 32'h3);
        chk("rst_rvalid",  {30'b0, i_rvalid, d_rvalid}, 32'h0);
        chk("rst_d_rdata", d_rdata, 32'h0);
        #2 nreset = 1'b1;
        @(negedge mem_clk);

        for (int x = 0; x < 272; x += 4) wr(x, 32'h0, 4'hF);
        for (int x = 32'hFF00; x < 32'h10000; x += 4) wr(x, 32'h0, 4'hF);

        wr(32'h10, 32'h1234_5678, 4'hF);
        step(1, 32'h10, 0, 0, 4'h0, 0, 0);
        watch(0, lowc, vc, data, err);
        chk("lat_ready_low", lowc, 3);
        chk("lat_rvalid_cnt", vc, 1);
        chk("lat_rdata", data, 32'h1234_5678);

        wr(32'h20, 32'hAABB_CCDD, 4'b0101);
        step(0, 0, 1, 0, 4'h0, 32'h20, 0);
        watch(1, lowc, vc, data, err);
        chk("be_rdata", data, 32'h00BB_00DD);
        chk("be_hold", d_rdata, 32'h00BB_00DD);

        step(1, 32'h40, 1, 1, 4'hF, 32'h40, 32'hFFFF_FFFF);
        watch(0, lowc, vc, data, err);
        chk("same_edge_old", data, 32'h0);
        step(1, 32'h40, 0, 0, 4'h0, 0, 0);
        watch(0, lowc, vc, data, err);
        chk("same_edge_new", data, 32'hFFFF_FFFF);

        wr(32'hFFFC, 32'h4433_2211, 4'hF);
        wr(32'h0,    32'h8877_6655, 4'hF);
        step(0, 0, 1, 0, 4'h0, 32'h0001_FFFE, 0);
        watch(1, lowc, vc, data, err);
        chk("wrap_rvalid", vc, 1);
        if (ALIGN) begin
            chk("unal_err", {31'b0, err}, 32'h1);
            chk("unal_rdata", data, 32'h0);
        end else begin
            chk("wrap_rdata", data, 32'h6655_4433);
            chk("wrap_err", {31'b0, err}, 32'h0);
        end

        step(1, 32'h10, 1, 0, 4'h0, 32'h20, 0);
        idle();
        #2 nreset = 1'b0;
        model_reset();
        #1;
        chk("mid_rst_ready",  {30'b0, i_ready, d_ready}, 32'h3);
        chk("mid_rst_rvalid", {30'b0, i_rvalid, d_rvalid}, 32'h0);
        chk("mid_rst_i_rdata", i_rdata, NOP);
        chk("mid_rst_d_rdata", d_rdata, 32'h0);
        @(negedge mem_clk);
        idle(); idle();
        #2 nreset = 1'b1;
        @(negedge mem_clk);
        watch(0, lowc, vc, data, err);
        chk("post_rst_no_rvalid", vc, 0);
        step(1, 32'h10, 0, 0, 4'h0, 0, 0);
        watch(0, lowc, vc, data, err);
        chk("post_rst_reread", data, 32'h1234_5678);

        for (int n = 0; n < 1500; n++) begin
            logic [31:0] ia, da;
            a  = ($urandom_range(0, 1) == 0) ? $urandom_range(0, 255) : 32'hFF00 + $urandom_range(0, 255);
            ia = {16'($urandom()), a[15:0]};
            a  = ($urandom_range(0, 1) == 0) ? $urandom_range(0, 255) : 32'hFF00 + $urandom_range(0, 255);
            if ($urandom_range(0, 1) == 0) a[1:0] = 2'b00;
            da = {16'($urandom()), a[15:0]};
            step($urandom_range(0, 2) != 0, ia, $urandom_range(0, 2) != 0,
                 $urandom_range(0, 1) == 1, 4'($urandom()), da, $urandom());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
